// File: rtl/pw_pattern_match_if.sv
// Front-end data/control bundle for the masked byte-pattern matcher.
// master drives data, pattern and arm controls; slave is the matcher.
interface pw_pattern_match_if #(
   parameter int pPATTERN_BYTES = 64,
   parameter int pLEN_WIDTH     = 7
);
   logic [7:0]                  I_data;
   logic                        I_data_valid;
   logic                        I_flush;
   logic [8*pPATTERN_BYTES-1:0] I_pattern;
   logic [8*pPATTERN_BYTES-1:0] I_mask;
   logic [pLEN_WIDTH-1:0]       I_pattern_bytes;
   logic                        I_arm;
   logic                        I_disarm;
   logic                        O_armed;
   logic                        O_match;
   logic [15:0]                 O_match_count;

   modport master (
      output I_data, I_data_valid, I_flush, I_pattern, I_mask, I_pattern_bytes,
             I_arm, I_disarm,
      input  O_armed, O_match, O_match_count
   );
   modport slave (
      input  I_data, I_data_valid, I_flush, I_pattern, I_mask, I_pattern_bytes,
             I_arm, I_disarm,
      output O_armed, O_match, O_match_count
   );
endinterface

// File: rtl/pw_pattern_match.sv
// Sliding-window masked byte-pattern matcher feeding the trigger stage.
// One single-cycle match pulse per arm; the compare result is registered (2-edge latency).
module pw_byte_cmp (
   input  logic [7:0] hist_i,
   input  logic [7:0] pat_i,
   input  logic [7:0] mask_i,
   input  logic       en_i,
   output logic       ok_o
);
   assign ok_o = !en_i || (((hist_i ^ pat_i) & mask_i) == 8'h00);
endmodule

module pw_pattern_match #(
   parameter int pPATTERN_BYTES = 64,
   parameter int pLEN_WIDTH     = 7
) (
   input  logic              fe_clk,
   input  logic              reset_i,
   pw_pattern_match_if.slave bus
);
   localparam logic [pLEN_WIDTH-1:0] MAX_LEN = pLEN_WIDTH'(pPATTERN_BYTES);

   typedef enum logic {DISARMED, ARMED} state_e;

   state_e                         state_q;
   logic [pPATTERN_BYTES-1:0][7:0] hist_q;
   logic [pLEN_WIDTH-1:0]          fill_q;
   logic [pLEN_WIDTH-1:0]          le_c;
   logic [pPATTERN_BYTES-1:0]      lane_ok;
   logic                           hit_c;
   logic                           match_d;
   logic                           match_q;
   logic [15:0]                    count_q;

   assign le_c = (bus.I_pattern_bytes > MAX_LEN) ? MAX_LEN : bus.I_pattern_bytes;

   // Lanes at or beyond the active length are forced to "ok".
   for (genvar k = 0; k < pPATTERN_BYTES; k++) begin : g_lane
      pw_byte_cmp u_cmp (
         .hist_i (hist_q[k]),
         .pat_i  (bus.I_pattern[8*k +: 8]),
         .mask_i (bus.I_mask[8*k +: 8]),
         .en_i   (pLEN_WIDTH'(k) < le_c),
         .ok_o   (lane_ok[k])
      );
   end

   assign hit_c   = (le_c != '0) && (fill_q >= le_c) && (&lane_ok);
   // Suppressing back-to-back pulses keeps an arm-on-hit from double firing.
   assign match_d = hit_c && (state_q == ARMED) && !match_q;

   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state_q <= DISARMED;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         count_q <= '0;
      end else begin
         if (bus.I_flush) begin
            fill_q <= '0;
         end else if (bus.I_data_valid) begin
            hist_q <= {hist_q[pPATTERN_BYTES-2:0], bus.I_data};
            if (fill_q != MAX_LEN) fill_q <= fill_q + pLEN_WIDTH'(1);
         end
         match_q <= match_d;
         if (match_d && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
         case (state_q)
            DISARMED: if (bus.I_arm && !bus.I_disarm) state_q <= ARMED;
            ARMED:    if (bus.I_disarm || (match_d && !bus.I_arm)) state_q <= DISARMED;
            default:  state_q <= DISARMED;
         endcase
      end
   end

   assign bus.O_armed       = (state_q == ARMED);
   assign bus.O_match       = match_q;
   assign bus.O_match_count = count_q;
endmodule

// File: tb/tb_pw_pattern_match.sv
// Bench for pw_pattern_match: directed scenarios plus randomized traffic against
// a queue-based reference of the received-byte history and arm/match rules.
module tb_pw_pattern_match;
   localparam int P  = 64;
   localparam int LW = 7;

   typedef struct {
      logic [7:0] d;
      bit v, fl, arm, dis;
   } stim_t;

   logic fe_clk = 1'b0;
   logic reset_i;

   pw_pattern_match_if #(.pPATTERN_BYTES(P), .pLEN_WIDTH(LW)) bus ();
   pw_pattern_match #(.pPATTERN_BYTES(P), .pLEN_WIDTH(LW)) dut (
      .fe_clk  (fe_clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 fe_clk = ~fe_clk;

   int nvec = 0, nerr = 0;
   logic [7:0] mq[$];   // received bytes since last flush/reset, newest first
   bit m_armed, m_match;
   int m_cnt;
   stim_t sq[$];

   function automatic bit model_hit();
      int le = (int'(bus.I_pattern_bytes) > P) ? P : int'(bus.I_pattern_bytes);
      if (le == 0 || mq.size() < le) return 1'b0;
      for (int k = 0; k < le; k++)
         if (((mq[k] ^ bus.I_pattern[8*k +: 8]) & bus.I_mask[8*k +: 8]) != 8'h00) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      mq.delete(); m_armed = 0; m_match = 0; m_cnt = 0;
   endtask

   task automatic add(input logic [7:0] d, input bit v, input bit fl, input bit arm, input bit dis);
      stim_t s;
      s.d = d; s.v = v; s.fl = fl; s.arm = arm; s.dis = dis;
      sq.push_back(s);
   endtask

   task automatic add_seq(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
      add(b2, 1, 0, 0, 0); add(b1, 1, 0, 0, 0); add(b0, 1, 0, 0, 0);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) add(8'h00, 0, 0, 0, 0);
   endtask

   // Apply one cycle at the current negedge; update the reference at the edge.
   task automatic step(input stim_t s);
      bit q;
      bus.I_data = s.d; bus.I_data_valid = s.v; bus.I_flush = s.fl;
      bus.I_arm = s.arm; bus.I_disarm = s.dis;
      @(posedge fe_clk);
      q = model_hit() && m_armed && !m_match;
      if (s.dis) m_armed = 0; else if (s.arm) m_armed = 1; else if (q) m_armed = 0;
      m_match = q;
      if (q && m_cnt < 65535) m_cnt++;
      if (s.fl) mq.delete();
      else if (s.v) begin
         mq.push_front(s.d);
         if (mq.size() > P) void'(mq.pop_back());
      end
      @(negedge fe_clk);
      bus.I_data_valid = 0; bus.I_flush = 0; bus.I_arm = 0; bus.I_disarm = 0;
   endtask

   task automatic set_pat();
      bus.I_pattern = '0;
      bus.I_pattern[7:0] = 8'h2D; bus.I_pattern[15:8] = 8'h69; bus.I_pattern[23:16] = 8'hA5;
      bus.I_mask = '1;
      bus.I_pattern_bytes = LW'(3);
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      bus.I_data = 0; bus.I_data_valid = 0; bus.I_flush = 0; bus.I_arm = 0; bus.I_disarm = 0;
      set_pat();
      model_reset();
      #13;
      nvec++;
      if ({bus.O_match, bus.O_armed, bus.O_match_count} !== 18'd0) begin
         nerr++;
         $display("FAIL reset_state: got match/armed/count %b/%b/%0d want 0/0/0",
                  bus.O_match, bus.O_armed, bus.O_match_count);
      end
      @(negedge fe_clk); reset_i = 1'b0;
   endtask

   task automatic test_basic();
      int np = 0, pidx = -1;
      set_pat();
      sq.delete(); add(0, 0, 1, 1, 0); add_seq(8'hA5, 8'h69, 8'h2D); add_idle(3);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL basic step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) begin np++; if (pidx < 0) pidx = i; end
      end
      nvec++;
      if (np != 1 || pidx != 4 || bus.O_armed !== 1'b0 || bus.O_match_count !== 16'd1) begin
         nerr++;
         $display("FAIL basic_pulse: got pulses=%0d at step %0d armed=%b count=%0d want 1 at 4, 0, 1",
                  np, pidx, bus.O_armed, bus.O_match_count);
      end
   endtask

   task automatic test_rearm();
      int want[2] = '{1, 2};
      for (int c = 0; c < 2; c++) begin
         int np = 0;
         sq.delete();
         add(0, 0, 1, 1, 0); add_seq(8'hA5, 8'h69, 8'h2D); add_idle(2);
         if (c == 1) add(0, 0, 1, 1, 0);
         add_seq(8'hA5, 8'h69, 8'h2D); add_idle(3);
         foreach (sq[i]) begin
            step(sq[i]);
            nvec++;
            if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
               nerr++;
               $display("FAIL rearm case %0d step %0d: got %b/%b/%0d want %b/%b/%0d", c, i,
                        bus.O_match, bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
            end
            if (bus.O_match) np++;
         end
         nvec++;
         if (np != want[c]) begin
            nerr++;
            $display("FAIL rearm_pulses case %0d: got %0d want %0d", c, np, want[c]);
         end
      end
      nvec++;
      if (bus.O_match_count !== 16'd4) begin
         nerr++;
         $display("FAIL rearm_count: got %0d want 4", bus.O_match_count);
      end
   endtask

   task automatic test_mask();
      logic [7:0] mb[3]  = '{8'h00, 8'h0F, 8'h0F};
      logic [7:0] mid[3] = '{8'hFF, 8'hF9, 8'hF8};
      int want[3] = '{1, 1, 0};
      for (int c = 0; c < 3; c++) begin
         int np = 0;
         bus.I_mask[15:8] = mb[c];
         sq.delete(); add(0, 0, 1, 1, 0); add_seq(8'hA5, mid[c], 8'h2D); add_idle(3);
         foreach (sq[i]) begin
            step(sq[i]);
            nvec++;
            if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
               nerr++;
               $display("FAIL mask case %0d step %0d: got %b/%b/%0d want %b/%b/%0d", c, i,
                        bus.O_match, bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
            end
            if (bus.O_match) np++;
         end
         nvec++;
         if (np != want[c]) begin
            nerr++;
            $display("FAIL mask_pulses case %0d: got %0d want %0d", c, np, want[c]);
         end
      end
      step('{d: 8'h00, v: 0, fl: 0, arm: 0, dis: 1});
      bus.I_mask = '1;
   endtask

   task automatic test_flush();
      int np = 0;
      set_pat();
      sq.delete();
      add(0, 0, 1, 1, 0); add(8'hA5, 1, 0, 0, 0); add(8'h69, 1, 1, 0, 0); add(8'h2D, 1, 0, 0, 0);
      add_idle(3);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL flush step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) np++;
      end
      nvec++;
      if (np != 0 || bus.O_armed !== 1'b1) begin
         nerr++;
         $display("FAIL flush_nomatch: got pulses=%0d armed=%b want 0, 1", np, bus.O_armed);
      end
      sq.delete(); add_seq(8'hA5, 8'h69, 8'h2D); add_idle(3);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL flush_refill step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) np++;
      end
      nvec++;
      if (np != 1) begin
         nerr++;
         $display("FAIL flush_refill_pulses: got %0d want 1", np);
      end
   endtask

   task automatic test_len();
      int np = 0, pidx = -1;
      logic [7:0] alpha[4] = '{8'hA5, 8'h69, 8'h2D, 8'h00};
      bus.I_pattern_bytes = '0;
      sq.delete(); add(0, 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) add(alpha[$urandom_range(3)], 1, 0, 0, 0);
      add_seq(8'hA5, 8'h69, 8'h2D); add_idle(2);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL len0 step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) np++;
      end
      nvec++;
      if (np != 0 || bus.O_armed !== 1'b1) begin
         nerr++;
         $display("FAIL len0_nomatch: got pulses=%0d armed=%b want 0, 1", np, bus.O_armed);
      end
      step('{d: 8'h00, v: 0, fl: 0, arm: 0, dis: 1});
      bus.I_pattern_bytes = LW'(127);
      bus.I_mask = '0;
      np = 0;
      sq.delete(); add(0, 0, 1, 1, 0);
      for (int i = 0; i < 66; i++) add(8'($urandom), 1, 0, 0, 0);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL len127 step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) begin np++; if (pidx < 0) pidx = i; end
      end
      nvec++;
      if (np != 1 || pidx != 65) begin
         nerr++;
         $display("FAIL len127_pulse: got pulses=%0d at step %0d want 1 at 65", np, pidx);
      end
   endtask

   task automatic test_arm_hit();
      int np = 0;
      set_pat();
      sq.delete(); add(0, 0, 1, 1, 0); add_seq(8'hA5, 8'h69, 8'h2D);
      add(8'h00, 1, 0, 1, 0); add_idle(3);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL arm_hit step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) np++;
      end
      nvec++;
      if (np != 1 || bus.O_armed !== 1'b1) begin
         nerr++;
         $display("FAIL arm_hit_stays: got pulses=%0d armed=%b want 1, 1", np, bus.O_armed);
      end
   endtask

   task automatic test_async_reset();
      int np = 0;
      set_pat();
      sq.delete(); add(0, 0, 1, 1, 0); add(8'hA5, 1, 0, 0, 0); add(8'h69, 1, 0, 0, 0);
      foreach (sq[i]) step(sq[i]);
      #2 reset_i = 1'b1;
      model_reset();
      #1;
      nvec++;
      if ({bus.O_match, bus.O_armed, bus.O_match_count} !== 18'd0) begin
         nerr++;
         $display("FAIL async_reset: got match/armed/count %b/%b/%0d want 0/0/0",
                  bus.O_match, bus.O_armed, bus.O_match_count);
      end
      @(negedge fe_clk); reset_i = 1'b0;
      sq.delete(); add(0, 0, 0, 1, 0); add(8'h2D, 1, 0, 0, 0); add_idle(3);
      foreach (sq[i]) begin
         step(sq[i]);
         nvec++;
         if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
            nerr++;
            $display("FAIL post_reset step %0d: got %b/%b/%0d want %b/%b/%0d", i, bus.O_match,
                     bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
         end
         if (bus.O_match) np++;
      end
      nvec++;
      if (np != 0) begin
         nerr++;
         $display("FAIL post_reset_tail: got %0d pulses want 0", np);
      end
   endtask

   task automatic test_random();
      logic [7:0] alpha[4] = '{8'hA5, 8'h69, 8'h2D, 8'h00};
      logic [7:0] mopt[3]  = '{8'hFF, 8'h0F, 8'h00};
      for (int blk = 0; blk < 4; blk++) begin
         step('{d: 8'h00, v: 0, fl: 0, arm: 0, dis: 1});
         bus.I_pattern = '0; bus.I_mask = '1;
         bus.I_pattern_bytes = LW'($urandom_range(1, 4));
         for (int k = 0; k < 4; k++) begin
            bus.I_pattern[8*k +: 8] = alpha[$urandom_range(3)];
            bus.I_mask[8*k +: 8]    = mopt[$urandom_range(2)];
         end
         sq.delete();
         for (int i = 0; i < 150; i++)
            add(alpha[$urandom_range(3)], $urandom_range(3) != 0, $urandom_range(29) == 0,
                $urandom_range(7) == 0, $urandom_range(39) == 0);
         foreach (sq[i]) begin
            step(sq[i]);
            nvec++;
            if ({bus.O_match, bus.O_armed, bus.O_match_count} !== {m_match, m_armed, 16'(m_cnt)}) begin
               nerr++;
               $display("FAIL random blk %0d step %0d: got %b/%b/%0d want %b/%b/%0d", blk, i,
                        bus.O_match, bus.O_armed, bus.O_match_count, m_match, m_armed, m_cnt);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rearm();
      test_mask();
      test_flush();
      test_len();
      test_arm_hit();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
